// File: rtl/branch_unit_if.sv
// Fetch-lookup and EX-resolution bus of the branch unit.
// master: the pipeline side (drives lookups and resolving branches).
// slave:  the branch unit (returns predictions and resolution results).
interface branch_unit_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  // Fetch-side lookup
  logic            if_valid;
  logic [PC_W-1:0] if_pc;
  logic            pred_valid;
  logic            pred_taken;

  // EX-side resolution
  logic            ex_valid;
  logic [2:0]      ex_op;
  logic [XLEN-1:0] ex_c;
  logic [PC_W-1:0] ex_pc;
  logic            ex_pred_taken;
  logic            res_valid;
  logic            res_taken;
  logic            res_mispredict;

  modport master (
    output if_valid, if_pc, ex_valid, ex_op, ex_c, ex_pc, ex_pred_taken,
    input  pred_valid, pred_taken, res_valid, res_taken, res_mispredict
  );

  modport slave (
    input  if_valid, if_pc, ex_valid, ex_op, ex_c, ex_pc, ex_pred_taken,
    output pred_valid, pred_taken, res_valid, res_taken, res_mispredict
  );
endinterface

// File: rtl/branch_unit.sv
// Branch resolution and prediction unit.
// - Resolves branch conditions at EX from the ALU difference ex_c (signed).
// - Direct-mapped BHT of 2-bit saturating counters indexed by pc[IDX_W+1:2].
// - Registered prediction to fetch and registered resolution/mispredict flags.
// Optional feature macro: BRANCH_STATS_EN adds stat_branches/stat_mispredicts.
// Condition codes mirror the core's BR_* encodings:
//   NO=0, NE=1, EQ=2, GE=3, LT=4, GO=5, 6/7 undefined (behave as NO).
module branch_unit #(
  parameter int XLEN      = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_unit_if.slave       bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]        stat_branches,
  output logic [31:0]        stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [2:0] BR_NO = 3'd0;
  localparam logic [2:0] BR_NE = 3'd1;
  localparam logic [2:0] BR_EQ = 3'd2;
  localparam logic [2:0] BR_GE = 3'd3;
  localparam logic [2:0] BR_LT = 3'd4;
  localparam logic [2:0] BR_GO = 3'd5;

  localparam logic [1:0] CTR_RESET = 2'b01;  // weakly not-taken

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             ex_cond;      // op is conditional (may train the BHT)
  logic             ex_taken;     // actual direction of the resolving branch
  logic             ex_mispredict;
  logic [1:0]       ctr_next;
  logic             unused_pc_bits;

  assign if_idx = bus.if_pc[IDX_W+1:2];
  assign ex_idx = bus.ex_pc[IDX_W+1:2];

  // PC bits outside the index field carry no information for an untagged BHT.
  assign unused_pc_bits = ^{bus.if_pc[PC_W-1:IDX_W+2], bus.if_pc[1:0],
                            bus.ex_pc[PC_W-1:IDX_W+2], bus.ex_pc[1:0]};

  // Decode the condition code and evaluate the branch direction.
  always_comb begin
    ex_cond  = 1'b0;
    ex_taken = 1'b0;
    unique case (bus.ex_op)
      BR_NO: ex_taken = 1'b0;
      BR_NE: begin ex_cond = 1'b1; ex_taken = (bus.ex_c != '0);     end
      BR_EQ: begin ex_cond = 1'b1; ex_taken = (bus.ex_c == '0);     end
      BR_GE: begin ex_cond = 1'b1; ex_taken = ~bus.ex_c[XLEN-1];    end
      BR_LT: begin ex_cond = 1'b1; ex_taken =  bus.ex_c[XLEN-1];    end
      BR_GO: ex_taken = 1'b1;
      default: ex_taken = 1'b0;
    endcase
    ex_mispredict = ex_taken ^ bus.ex_pred_taken;
  end

  // Saturating counter step for the entry being trained.
  always_comb begin
    ctr_next = bht[ex_idx];
    if (ex_taken) begin
      if (bht[ex_idx] != 2'b11) ctr_next = bht[ex_idx] + 2'b01;
    end else begin
      if (bht[ex_idx] != 2'b00) ctr_next = bht[ex_idx] - 2'b01;
    end
  end

  // BHT storage: trained by valid conditional resolutions only.
  // NOTE: the table lives in flops and is reset so every entry starts weakly
  // not-taken; a RAM macro could not offer this without an init sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_RESET;
    end else if (bus.ex_valid && ex_cond) begin
      bht[ex_idx] <= ctr_next;
    end
  end

  // Registered prediction to fetch.
  // NOTE: non-blocking writes mean a same-cycle lookup of the entry being
  // trained reads the pre-update counter (read-before-write, no bypass).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pred_valid <= 1'b0;
      bus.pred_taken <= 1'b0;
    end else begin
      bus.pred_valid <= bus.if_valid;
      bus.pred_taken <= bus.if_valid & bht[if_idx][1];
    end
  end

  // Registered resolution result, all flags qualified by ex_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.res_valid      <= 1'b0;
      bus.res_taken      <= 1'b0;
      bus.res_mispredict <= 1'b0;
    end else begin
      bus.res_valid      <= bus.ex_valid;
      bus.res_taken      <= bus.ex_valid & ex_taken;
      bus.res_mispredict <= bus.ex_valid & ex_mispredict;
    end
  end

`ifdef BRANCH_STATS_EN
  // Saturating event counters, stepping together with the res_* registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (bus.ex_valid && ex_cond && stat_branches != '1)
        stat_branches <= stat_branches + 32'd1;
      if (bus.ex_valid && ex_mispredict && stat_mispredicts != '1)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: doc/branch_unit.md
# branch_unit

Parametrised branch resolution and prediction unit for the CPU core. Evaluates branch conditions at EX with correct signed comparison, holds a direct-mapped branch history table (BHT) of 2-bit saturating counters indexed by PC, supplies a registered taken/not-taken prediction to fetch, and flags mispredictions one cycle after resolution.

## Interface
- `XLEN`, 32: width of the condition operand `ex_c` (the ALU difference A-B).
- `PC_W`, 32: program counter width.
- `BHT_DEPTH`, 64: number of BHT entries; power of two, 4..1024. `IDX_W = $clog2(BHT_DEPTH)`.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `if_valid`  in  1  fetch lookup request.
- `if_pc`  in  PC_W  fetch PC.
- `pred_valid`  out  1  prediction valid (registered).
- `pred_taken`  out  1  predicted direction (registered).
- `ex_valid`  in  1  branch resolving this cycle.
- `ex_op`  in  3  condition code, `BR_*` encodings from defines.vh (NO, NE, EQ, GE, LT, GO).
- `ex_c`  in  XLEN  condition operand.
- `ex_pc`  in  PC_W  PC of the resolving branch.
- `ex_pred_taken`  in  1  prediction that accompanied this branch.
- `res_valid`  out  1  resolution valid (registered).
- `res_taken`  out  1  actual direction.
- `res_mispredict`  out  1  `res_taken != ex_pred_taken`, qualified by `res_valid`.

## Operation
- Index: `idx = pc[IDX_W+1:2]` (word-aligned PCs); no tags, aliasing permitted.
- Condition: NO -> 0; NE -> `ex_c != 0`; EQ -> `ex_c == 0`; GE -> `$signed(ex_c) >= 0` (MSB clear); LT -> `$signed(ex_c) < 0` (MSB set); GO -> 1; undefined codes -> 0, treated as NO.
- Prediction: `pred_taken = bht[idx][1]`.
- Update: only for conditional ops (NE, EQ, GE, LT) with `ex_valid`. Taken -> counter+1, saturating at 2'b11; not taken -> counter-1, saturating at 2'b00. NO, GO and undefined codes never touch the BHT.
- Mispredict evaluated for every valid op, including NO/GO (GO with `ex_pred_taken=0` mispredicts).

## Timing
- Reset (async assert, sync-to-clk deassert by the top level): `pred_valid=0`, `pred_taken=0`, `res_valid=0`, `res_taken=0`, `res_mispredict=0`, all BHT entries 2'b01 (weakly not-taken). Reset mid-operation discards any in-flight lookup/resolution; no update is committed.
- Lookup latency 1: `if_valid` in cycle N -> `pred_valid/pred_taken` in N+1. `if_valid=0` -> `pred_valid=0`, `pred_taken=0` next cycle.
- Resolution latency 1: `ex_valid` in N -> `res_*` in N+1; BHT written at end of cycle N. `ex_valid=0` -> all `res_*` 0 next cycle.
- Lookup and update to the same index in the same cycle: lookup returns the pre-update counter (read-before-write, no bypass). Lookup in N+1 sees the update.
- Lookup and resolution are independent and may occur every cycle; no backpressure.

## Configuration
- `BRANCH_STATS_EN` defined: adds outputs `stat_branches` (32, count of valid conditional resolutions) and `stat_mispredicts` (32, count of valid resolutions with mispredict, all ops). Both reset to 0, increment in the cycle `res_valid` is asserted, saturate at 32'hFFFFFFFF.
- Undefined: ports and counters absent; functional behaviour otherwise identical.

## Test plan
- Reset, then `if_valid` with `if_pc=0x100` -> next cycle `pred_valid=1`, `pred_taken=0` (counter 01).
- `ex_op=LT`, `ex_c=32'h8000_0000`, `ex_pred_taken=0` -> `res_taken=1`, `res_mispredict=1`; `ex_op=GE`, same `ex_c` -> `res_taken=0`.
- Two taken EQ resolutions (`ex_c=0`) at PC 0x40 -> counter 11; lookup 0x40 -> `pred_taken=1`; third taken stays 11; three not-taken -> 00, fourth stays 00, prediction 0.
- Same-cycle lookup and taken update at PC 0x40 from counter 01 -> that lookup returns 0, following lookup returns 1; PC 0x40+4*BHT_DEPTH aliases the same entry.
- `ex_op=GO`, `ex_pred_taken=0` -> `res_taken=1`, `res_mispredict=1`, BHT unchanged; `ex_op=NO` with `ex_pred_taken=1` -> mispredict 1, BHT unchanged.
- With `BRANCH_STATS_EN`: 5 conditional resolutions, 2 mispredicted, plus 1 GO mispredict -> `stat_branches=5`, `stat_mispredicts=3`; assert `rst_n` low mid-stream -> both 0 immediately.
